mux_tree_pipe: RTL

//  Parametrised, fully pipelined N-input, WIDTH-bit multiplexer built as a binary tree of 2:1 stages.

---
 rtl/mux_tree_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/mux_tree_pipe.sv
// Pipelined N_IN:1 multiplexer built as a binary tree of registered 2:1 levels.
// Valid/ready handshake with a global stall; selects beyond N_IN return zero and raise out_sel_err.
module mux_tree_pipe #(
  parameter int N_IN  = 8,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [$clog2(N_IN)-1:0] in_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err
);

  localparam int SEL_W  = $clog2(N_IN);
  localparam int LEAVES = 2 ** SEL_W;
  localparam logic [SEL_W:0] NIN_V = N_IN[SEL_W:0];

  logic                    advance_s;
  logic                    in_err_s;
  logic [LEAVES*WIDTH-1:0] leaves_s;

  assign advance_s = out_ready | ~out_valid;
  assign in_ready  = advance_s;
  assign in_err_s  = ({1'b0, in_sel} >= NIN_V);

  // Zero-pad the channel vector up to a power-of-two leaf count.
  always_comb begin
    leaves_s                   = '0;
    leaves_s[N_IN*WIDTH-1:0]   = in_data;
  end

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int CNT = LEAVES >> (k + 1);

    logic [2*CNT*WIDTH-1:0] vin_s;
    logic [SEL_W-1-k:0]     sin_s;
    logic                   vldin_s;
    logic                   errin_s;
    logic [CNT*WIDTH-1:0]   red_s;
    logic [CNT*WIDTH-1:0]   data_r;
    logic                   valid_r;
    logic                   err_r;

    if (k == 0) begin : g_src
      assign vin_s   = leaves_s;
      assign sin_s   = in_sel;
      assign vldin_s = in_valid & advance_s;
      assign errin_s = in_err_s;
    end else begin : g_chain
      assign vin_s   = g_lvl[k-1].data_r;
      assign sin_s   = g_lvl[k-1].g_sel.sel_r;
      assign vldin_s = g_lvl[k-1].valid_r;
      assign errin_s = g_lvl[k-1].err_r;
    end

    // Level k resolves select bit k: each adjacent pair collapses to one entry.
    always_comb begin
      red_s = '0;
      for (int j = 0; j < CNT; j++) begin
        if (sin_s[0]) begin
          red_s[j*WIDTH +: WIDTH] = vin_s[(2*j+1)*WIDTH +: WIDTH];
        end else begin
          red_s[j*WIDTH +: WIDTH] = vin_s[(2*j)*WIDTH +: WIDTH];
        end
      end
    end

    // Stage register: every stage shifts together on advance, holds otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_r  <= '0;
        valid_r <= 1'b0;
        err_r   <= 1'b0;
      end else if (advance_s) begin
        data_r  <= red_s;
        valid_r <= vldin_s;
        err_r   <= errin_s;
      end
    end

    // The final level consumes the last select bit, so only earlier levels carry select bits on.
    if (k < SEL_W - 1) begin : g_sel
      logic [SEL_W-2-k:0] sel_r;

      // Remaining select bits travel alongside the data.
      always_ff @(posedge clk) begin
        if (rst) begin
          sel_r <= '0;
        end else if (advance_s) begin
          sel_r <= sin_s[SEL_W-1-k:1];
        end
      end
    end
  end

  assign out_valid   = g_lvl[SEL_W-1].valid_r;
  assign out_data    = g_lvl[SEL_W-1].data_r;
  assign out_sel_err = g_lvl[SEL_W-1].err_r;

endmodule
